// File: rtl/byte_packer_pkg.sv
// byte_packer_pkg: shared state encoding and lane-mask helper for byte_packer
package byte_packer_pkg;
  typedef enum logic [1:0] {
    EMPTY      = 2'd0,
    FILL       = 2'd1,
    FLUSH_WAIT = 2'd2
  } state_t;
  function automatic logic [7:0] lane_mask(input logic [3:0] n);
    return 8'((16'd1 << n) - 16'd1);
  endfunction
endpackage

// File: rtl/byte_packer_out_reg.sv
// byte_packer_out_reg: one-entry output slot holding a packed word until consumed
// Ports: i_clk/i_rst (async active-high), i_load + i_word/i_be (new word),
//        i_ready (consumer takes word), o_valid/o_word/o_be (slot contents),
//        o_parity (even parity per lane, only with BYTE_PACKER_PARITY_EN).
module byte_packer_out_reg
  import byte_packer_pkg::*;
#(
  parameter int P_BYTES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_load,
  input  logic [8*P_BYTES-1:0]   i_word,
  input  logic [P_BYTES-1:0]     i_be,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [8*P_BYTES-1:0]   o_word,
  output logic [P_BYTES-1:0]     o_be
`ifdef BYTE_PACKER_PARITY_EN
  ,
  output logic [P_BYTES-1:0]     o_parity
`endif
);
  // i_load is only raised by the top when the slot is free, so a load
  // always wins over a consume in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_word  <= '0;
      o_be    <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_word  <= i_word;
      o_be    <= i_be;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end
`ifdef BYTE_PACKER_PARITY_EN
  logic [P_BYTES-1:0] w_parity;
  // Unused lanes of a loaded word are zero, so their parity is 0 for free.
  for (genvar k = 0; k < P_BYTES; k++) begin : g_par
    assign w_parity[k] = ^i_word[8*k +: 8];
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_parity <= '0;
    else if (i_load) o_parity <= w_parity;
  end
`endif
endmodule

// File: rtl/byte_packer.sv
// byte_packer: packs P_BYTES consecutive bytes little-endian into one word with flush
// Ports: CLK_I/RST_I (async active-high), DATA_I/VALID_I/READY_O (byte input),
//        FLUSH_I (emit partial word), WORD_O/BYTE_EN_O/VALID_O/READY_I (word output),
//        OVERFLOW_O (sticky drop flag), PARITY_O (only with BYTE_PACKER_PARITY_EN).
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int P_BYTES = 4,
  parameter int P_DELAY = 1
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic [7:0]             DATA_I,
  input  logic                   VALID_I,
  output logic                   READY_O,
  input  logic                   FLUSH_I,
  output logic [8*P_BYTES-1:0]   WORD_O,
  output logic [P_BYTES-1:0]     BYTE_EN_O,
  output logic                   VALID_O,
  input  logic                   READY_I,
  output logic                   OVERFLOW_O
`ifdef BYTE_PACKER_PARITY_EN
  ,
  output logic [P_BYTES-1:0]     PARITY_O
`endif
);
  localparam int CW = $clog2(P_BYTES + 1);
  localparam logic [P_BYTES-1:0] LP_ALL = {P_BYTES{1'b1}};
  if (P_BYTES < 2 || P_BYTES > 8 || P_DELAY < 0) begin : g_bad_cfg
  end
  state_t               r_state, w_nxt_state;
  logic [CW-1:0]        r_cnt, w_nxt_cnt, w_n;
  logic [8*P_BYTES-1:0] r_acc, w_nxt_acc, w_merged;
  logic [P_BYTES-1:0]   w_ld_be;
  logic [7:0]           w_mask;
  logic                 w_slot_free, w_pend, w_acc, w_full, w_flush, w_ld, r_ovf;
  assign w_slot_free = ~VALID_O | READY_I;
  assign w_pend      = r_state == FLUSH_WAIT;
  assign READY_O     = ~RST_I & ~w_pend & ((r_cnt < CW'(P_BYTES-1)) | w_slot_free);
  assign w_acc       = VALID_I & READY_O;
  assign w_full      = w_acc & (r_cnt == CW'(P_BYTES-1));
  // A flush that coincides with the filling byte is just a full-word load.
  assign w_flush     = FLUSH_I & ~w_pend & ~w_full & ((r_cnt != '0) | w_acc);
  assign w_n         = r_cnt + CW'(w_acc);
  assign w_mask      = lane_mask(4'(w_n));
  assign OVERFLOW_O  = r_ovf;
  // w_merged is the accumulator including any byte accepted this cycle; in
  // FLUSH_WAIT no byte can be accepted, so it equals the parked partial word.
  always_comb begin
    w_merged = r_acc;
    if (w_acc) w_merged[8*r_cnt +: 8] = DATA_I;
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_acc   = r_acc;
    w_ld        = 1'b0;
    w_ld_be     = w_full ? LP_ALL : P_BYTES'(w_mask);
    if (((w_pend | w_flush) & w_slot_free) | w_full) begin
      w_ld        = 1'b1;
      w_nxt_state = EMPTY;
      w_nxt_cnt   = '0;
      w_nxt_acc   = '0;
    end else if (w_flush) begin
      w_nxt_state = FLUSH_WAIT;
      w_nxt_cnt   = w_n;
      w_nxt_acc   = w_merged;
    end else if (w_acc) begin
      w_nxt_state = FILL;
      w_nxt_cnt   = w_n;
      w_nxt_acc   = w_merged;
    end
  end
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= EMPTY;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_acc   <= w_nxt_acc;
      r_ovf   <= r_ovf | (VALID_I & ~READY_O);
    end
  end
  byte_packer_out_reg #(.P_BYTES(P_BYTES)) u_out (
    .i_clk    (CLK_I),
    .i_rst    (RST_I),
    .i_load   (w_ld),
    .i_word   (w_merged),
    .i_be     (w_ld_be),
    .i_ready  (READY_I),
    .o_valid  (VALID_O),
    .o_word   (WORD_O),
    .o_be     (BYTE_EN_O)
`ifdef BYTE_PACKER_PARITY_EN
    ,
    .o_parity (PARITY_O)
`endif
  );
endmodule
